// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a valid/ready handshake on both sides.
// Single-cycle operations are delivered one edge after acceptance. MULT/DIV
// operations wait in MC_WAIT for a fixed number of edges before delivery.
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              multi_cycle,
  output logic              illegal,
  output logic              busy
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // Counter is loaded with N-1 on the acceptance edge, so the total
  // acceptance-to-out_valid latency is exactly N edges.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MULT = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
  logic              mc_reg, mc_next;
  logic              ill_reg, ill_next;

  logic [3:0] dec_code;
  logic       dec_mc;
  logic       dec_div;
  logic       dec_ill;
  logic       accept;

  // Combinational decode of the presented alu_op/funct.
  always_comb begin
    dec_code = OP_ADD;
    dec_mc   = 1'b0;
    dec_div  = 1'b0;
    dec_ill  = 1'b0;
    case (alu_op)
      2'b00: dec_code = OP_ADD;
      2'b01: dec_code = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: dec_code = OP_ADD;
          6'b100010, 6'b100011: dec_code = OP_SUB;
          6'b100100:            dec_code = OP_AND;
          6'b100101:            dec_code = OP_OR;
          6'b100110:            dec_code = OP_XOR;
          6'b100111:            dec_code = OP_NOR;
          6'b101010:            dec_code = OP_SLT;
          6'b101011:            dec_code = OP_SLTU;
          6'b000000:            dec_code = OP_SLL;
          6'b000010:            dec_code = OP_SRL;
          6'b000011:            dec_code = OP_SRA;
          6'b011000, 6'b011001: begin
            dec_code = OP_MULT;
            dec_mc   = 1'b1;
          end
          6'b011010, 6'b011011: begin
            dec_code = OP_DIV;
            dec_mc   = 1'b1;
            dec_div  = 1'b1;
          end
          default:              dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Handshake: rst_n gates in_ready so nothing looks acceptable during reset;
  // flush blocks acceptance outright.
  assign in_ready = rst_n && !flush &&
                    ((state_reg == IDLE) || ((state_reg == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // Next-state, counter and held-result logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ctrl_next  = ctrl_reg;
    mc_next    = mc_reg;
    ill_next   = ill_reg;
    if (flush) begin
      // Abort whatever is in flight; the held result fields stay as they are.
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: state_next = IDLE;
        HOLD: begin
          if (out_ready) state_next = IDLE;
        end
        MC_WAIT: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_next = HOLD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
      // Acceptance overrides the HOLD->IDLE move, giving back-to-back issue.
      if (accept) begin
        ctrl_next = CTRL_W'(dec_code);
        mc_next   = dec_mc;
        ill_next  = dec_ill;
        if (dec_mc) begin
          state_next = MC_WAIT;
          cnt_next   = dec_div ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
    end
  end

  // State, counter and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ctrl_reg  <= '0;
      mc_reg    <= 1'b0;
      ill_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ctrl_reg  <= ctrl_next;
      mc_reg    <= mc_next;
      ill_reg   <= ill_next;
    end
  end

  assign out_valid   = (state_reg == HOLD);
  assign busy        = (state_reg == MC_WAIT);
  assign ctrl_out    = ctrl_reg;
  assign multi_cycle = mc_reg;
  assign illegal     = ill_reg;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: directed scenarios followed by random traffic.
// A timestamp-based model predicts handshake timing; expected results go into
// a scoreboard queue that a separate monitor checks whenever out_valid is high.
module tb_alu_ctrl_seq;

  localparam int CTRL_W     = 4;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic              multi_cycle;
  logic              illegal;
  logic              busy;

  alu_ctrl_seq #(
    .CTRL_W    (CTRL_W),
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .funct      (funct),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ctrl_out   (ctrl_out),
    .multi_cycle(multi_cycle),
    .illegal    (illegal),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    bit         mc;
    bit         ill;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Model: one outstanding operation at most, described by the edge number at
  // which its result becomes visible.
  int cyc    = 0;
  bit m_pend = 0;
  int m_rdy  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Reference decode straight from the operation table.
  function automatic exp_t ref_decode(input logic [1:0] op, input logic [5:0] fn);
    exp_t e;
    e.code = 4'd0; e.mc = 0; e.ill = 0; e.lat = 1;
    if (op == 2'b00) e.code = 4'd0;
    else if (op == 2'b01) e.code = 4'd1;
    else if (op == 2'b11) e.ill = 1;
    else begin
      case (fn)
        6'h20, 6'h21: e.code = 4'd0;
        6'h22, 6'h23: e.code = 4'd1;
        6'h24: e.code = 4'd2;
        6'h25: e.code = 4'd3;
        6'h26: e.code = 4'd5;
        6'h27: e.code = 4'd6;
        6'h2a: e.code = 4'd4;
        6'h2b: e.code = 4'd7;
        6'h00: e.code = 4'd8;
        6'h02: e.code = 4'd9;
        6'h03: e.code = 4'd10;
        6'h18, 6'h19: begin e.code = 4'd11; e.mc = 1; e.lat = MUL_CYCLES; end
        6'h1a, 6'h1b: begin e.code = 4'd12; e.mc = 1; e.lat = DIV_CYCLES; end
        default: e.ill = 1;
      endcase
    end
    return e;
  endfunction

  // One clock cycle: drive inputs, check handshake timing, advance the model.
  task automatic step(input bit iv, input logic [1:0] op, input logic [5:0] fn,
                      input bit ordy, input bit fl);
    bit   exp_valid, exp_busy, exp_ready;
    exp_t e;
    in_valid  = iv;
    alu_op    = op;
    funct     = fn;
    out_ready = ordy;
    flush     = fl;
    exp_valid = m_pend && (cyc >= m_rdy);
    exp_busy  = m_pend && (cyc < m_rdy);
    exp_ready = !fl && (!m_pend || (exp_valid && ordy));
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(exp_busy));
    #1;
    if (fl) begin
      m_pend = 0;
      sb_q.delete();
    end else begin
      if (exp_valid && ordy) m_pend = 0;
      if (iv && exp_ready) begin
        e      = ref_decode(op, fn);
        m_pend = 1;
        m_rdy  = cyc + e.lat;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 6'h00, 1, 0);
  endtask

  // Monitor: whenever a result is presented it must match the scoreboard head;
  // the head is retired on the handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q[0];
          chk("ctrl_out", 32'(ctrl_out), 32'(e.code));
          chk("multi_cycle", 32'(multi_cycle), 32'(e.mc));
          chk("illegal", 32'(illegal), 32'(e.ill));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  logic [5:0] legal_fn [17];
  logic [5:0] stream_fn [5];

  initial begin
    legal_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                 6'h2b, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h1a, 6'h1b};
    stream_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    // Reset state, with an input offered to confirm nothing is ready.
    rst_n = 0; flush = 0; in_valid = 1; alu_op = 2'b01; funct = 6'h00; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctrl_out", 32'(ctrl_out), 32'd0);
    chk("rst_multi_cycle", 32'(multi_cycle), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1;

    // Back-to-back R-type stream, first op on the first edge after release.
    for (int i = 0; i < 5; i++) step(1, 2'b10, stream_fn[i], 1, 0);
    idle(2);

    // MULT then DIV latency.
    step(1, 2'b10, 6'h18, 1, 0);
    idle(MUL_CYCLES + 1);
    step(1, 2'b10, 6'h1a, 1, 0);
    idle(DIV_CYCLES + 1);

    // Illegal funct and illegal alu_op.
    step(1, 2'b10, 6'h3f, 1, 0);
    step(1, 2'b11, 6'h20, 1, 0);
    idle(2);

    // Stall for 5 cycles with new input offered, then release and accept.
    step(1, 2'b00, 6'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 2'b01, 6'h00, 0, 0);
    step(1, 2'b01, 6'h00, 1, 0);
    idle(2);

    // Flush two cycles into a DIV, together with in_valid.
    step(1, 2'b10, 6'h1a, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    step(1, 2'b00, 6'h00, 1, 1);
    step(1, 2'b01, 6'h00, 1, 0);
    idle(2);

    // Asynchronous reset in the middle of a MULT.
    step(1, 2'b10, 6'h19, 1, 0);
    step(0, 2'b00, 6'h00, 1, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_ctrl_out", 32'(ctrl_out), 32'd0);
    chk("mid_rst_multi_cycle", 32'(multi_cycle), 32'd0);
    m_pend = 0;
    sb_q.delete();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1;
    step(1, 2'b01, 6'h00, 1, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         iv, ordy, fl;
      logic [1:0] op;
      logic [5:0] fn;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 39) == 0);
      op   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) fn = legal_fn[$urandom_range(0, 16)];
      else fn = 6'($urandom_range(0, 63));
      step(iv, op, fn, ordy, fl);
    end
    idle(DIV_CYCLES + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
